ll_rx_sync_monitor: RTL

Receive-side counterpart of the link-layer auto-sync transmitter: watches the incoming AIB PHY beat (`rx_phy0`) for the periodic strobe userbit and the per-word marker userbits inserted by the far end's transmit path. It acquires and tracks strobe phase and declares word alignment. It also counts strobe and marker violations for debug status. It sits between the PHY receive bus and the concat/unpack stage in each LPIF/LL top, in the `clk_wr` domain.

---
 rtl/ll_rx_sync_pkg.sv | 23 ++
 rtl/ll_sat_cnt.sv | 26 ++
 rtl/ll_rx_sync_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ll_rx_sync_pkg.sv
// ll_rx_sync_pkg: shared types and widths for the link-layer receive sync monitor.
//   ll_rx_sync_state_e : 2-bit sync FSM state (IDLE/SEARCH/VERIFY/LOCKED)
//   PHASE_W / GOOD_W / MISS_W : internal counter widths
//   STB_CNT_W / MRK_CNT_W     : statistic counter widths
package ll_rx_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } ll_rx_sync_state_e;

    // Beat phase since the last accepted strobe; matches the 8-bit stb_interval.
    localparam int unsigned PHASE_W = 8;
    // Good-strobe and miss-run counters cover LOCK_COUNT/MISS_LIMIT up to 15.
    localparam int unsigned GOOD_W  = 4;
    localparam int unsigned MISS_W  = 4;

    localparam int unsigned STB_CNT_W = 8;
    localparam int unsigned MRK_CNT_W = 16;

endpackage : ll_rx_sync_pkg

// File: rtl/ll_sat_cnt.sv
// ll_sat_cnt: saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : add one (held at all-ones once saturated)
//   clr      : synchronous clear, wins over inc
//   cnt      : registered count
module ll_sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule : ll_sat_cnt

// File: rtl/ll_rx_sync_monitor.sv
// ll_rx_sync_monitor: receive-side strobe/marker sync monitor for the AIB PHY beat.
// Acquires strobe phase (SEARCH -> VERIFY -> LOCKED), flywheels while locked,
// and keeps saturating debug counts of strobe violations and marker errors.
// Optional marker checking is built when LL_RX_SYNC_MRK_CHECK_EN is defined;
// otherwise mrk_err_cnt is tied to zero.
//   clk_wr, rst_wr  : clock, asynchronous active-high reset
//   rx_online       : enables monitoring; low forces IDLE
//   stb_interval    : expected strobe spacing in beats (0 treated as 1)
//   clr_cnt         : synchronous clear of both statistic counters
//   rx_phy0         : received PHY beat
//   rx_aligned      : high in LOCKED
//   rx_sync_state   : IDLE=0 SEARCH=1 VERIFY=2 LOCKED=3
//   lock_event      : one-cycle pulse on entry to LOCKED
//   stb_miss_cnt    : saturating strobe violation count (LOCKED only)
//   mrk_err_cnt     : saturating marker-mismatch beat count (LOCKED only)
module ll_rx_sync_monitor
    import ll_rx_sync_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 2,
    parameter int unsigned WORD_WIDTH = 80,
    parameter int unsigned STB_BIT    = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic                            clk_wr,
    input  logic                            rst_wr,
    input  logic                            rx_online,
    input  logic [PHASE_W-1:0]              stb_interval,
    input  logic                            clr_cnt,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] rx_phy0,
    output logic                            rx_aligned,
    output logic [1:0]                      rx_sync_state,
    output logic                            lock_event,
    output logic [STB_CNT_W-1:0]            stb_miss_cnt,
    output logic [MRK_CNT_W-1:0]            mrk_err_cnt
);

    ll_rx_sync_state_e   state, state_nxt;
    logic [PHASE_W-1:0]  phase_cnt, phase_nxt;
    logic [GOOD_W-1:0]   good_cnt, good_nxt;
    logic [MISS_W-1:0]   miss_run, miss_nxt;
    logic                stb_q;
    logic [PHASE_W-1:0]  exp_phase_c;
    logic                at_exp_c;
    logic [GOOD_W-1:0]   good_inc_c;
    logic [MISS_W-1:0]   miss_inc_c;
    logic                stb_viol_c;
    logic                unused_phy;

    // Only the strobe and marker bits are inspected; the payload passes by.
    assign unused_phy = ^rx_phy0;

    // Input stage: strobe bit registered every cycle.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= rx_phy0[STB_BIT];
        end
    end

    assign exp_phase_c = (stb_interval == '0) ? PHASE_W'(1) : stb_interval;
    assign at_exp_c    = (phase_cnt == exp_phase_c);
    assign good_inc_c  = good_cnt + GOOD_W'(1);
    assign miss_inc_c  = miss_run + MISS_W'(1);

    // State register and registered state decodes.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            good_cnt   <= '0;
            miss_run   <= '0;
            rx_aligned <= 1'b0;
            lock_event <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_nxt;
            good_cnt   <= good_nxt;
            miss_run   <= miss_nxt;
            rx_aligned <= (state_nxt == ST_LOCKED);
            lock_event <= (state_nxt == ST_LOCKED) && (state != ST_LOCKED);
        end
    end

    assign rx_sync_state = state;

    // Next-state logic; rx_online low overrides every other transition.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_cnt + PHASE_W'(1);
        good_nxt   = good_cnt;
        miss_nxt   = miss_run;
        stb_viol_c = 1'b0;

        if (!rx_online) begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
            good_nxt  = '0;
            miss_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_SEARCH;
                    phase_nxt = '0;
                end
                ST_SEARCH: begin
                    phase_nxt = '0;
                    if (stb_q) begin
                        good_nxt  = GOOD_W'(1);
                        phase_nxt = PHASE_W'(1);
                        miss_nxt  = '0;
                        state_nxt = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (stb_q && at_exp_c) begin
                        good_nxt  = good_inc_c;
                        phase_nxt = PHASE_W'(1);
                        if (good_inc_c == GOOD_W'(LOCK_COUNT)) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (stb_q) begin
                        // Early strobe: restart verification on the new phase.
                        good_nxt  = GOOD_W'(1);
                        phase_nxt = PHASE_W'(1);
                    end else if (at_exp_c) begin
                        state_nxt = ST_SEARCH;
                        phase_nxt = '0;
                        good_nxt  = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the phase wraps at the expected beat regardless of the strobe.
                    if (at_exp_c) begin
                        phase_nxt = PHASE_W'(1);
                    end
                    stb_viol_c = stb_q ^ at_exp_c;
                    if (stb_viol_c) begin
                        miss_nxt = miss_inc_c;
                        if (miss_inc_c == MISS_W'(MISS_LIMIT)) begin
                            state_nxt = ST_SEARCH;
                            miss_nxt  = '0;
                            good_nxt  = '0;
                            phase_nxt = '0;
                        end
                    end else if (stb_q) begin
                        miss_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    ll_sat_cnt #(
        .WIDTH (STB_CNT_W)
    ) u_stb_miss_cnt (
        .clk (clk_wr),
        .rst (rst_wr),
        .inc (stb_viol_c),
        .clr (clr_cnt),
        .cnt (stb_miss_cnt)
    );

`ifdef LL_RX_SYNC_MRK_CHECK_EN
    // Only the last word of a beat carries a set marker.
    localparam logic [NUM_WORDS-1:0] MRK_EXP = NUM_WORDS'(1) << (NUM_WORDS - 1);

    logic [NUM_WORDS-1:0] mrk_q;
    logic                 mrk_bad_c;

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            mrk_q <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                mrk_q[k] <= rx_phy0[k*WORD_WIDTH + WORD_WIDTH - 1];
            end
        end
    end

    assign mrk_bad_c = rx_online && (state == ST_LOCKED) && (mrk_q != MRK_EXP);

    ll_sat_cnt #(
        .WIDTH (MRK_CNT_W)
    ) u_mrk_err_cnt (
        .clk (clk_wr),
        .rst (rst_wr),
        .inc (mrk_bad_c),
        .clr (clr_cnt),
        .cnt (mrk_err_cnt)
    );
`else
    assign mrk_err_cnt = MRK_CNT_W'(0);
`endif

endmodule : ll_rx_sync_monitor
